// File: rtl/instr_fetch_queue_pkg.sv
// Shared parameters, types and helpers for the instruction fetch queue.
// The queue stores whole cache lines. Dispatch reads one word at a time from the head.
`timescale 1ns/1ps
package instr_fetch_queue_pkg;

    localparam int XLEN       = 32;
    localparam int LINE_WORDS = 4;
    localparam int DEPTH      = 4;
    localparam int LINE_W     = XLEN * LINE_WORDS;

    // Row index width, plus one wrap bit so that full and empty can be told apart
    localparam int ROW_W = $clog2(DEPTH);
    localparam int PTR_W = ROW_W + 1;

    // Word offset inside a line, and the byte layout of addresses
    localparam int OFF_W         = $clog2(LINE_WORDS);
    localparam int WORD_BYTES    = XLEN / 8;
    localparam int BYTE_OFF_W    = $clog2(WORD_BYTES);
    localparam int LINE_BYTES    = WORD_BYTES * LINE_WORDS;
    localparam int LINE_ADDR_LSB = OFF_W + BYTE_OFF_W;

    typedef logic [XLEN-1:0]   addr_t;
    typedef logic [XLEN-1:0]   word_t;
    typedef logic [LINE_W-1:0] line_t;
    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [OFF_W-1:0]  off_t;

    // The read pointer is a row pointer (with wrap bit) plus a word offset in that row
    typedef struct packed {
        ptr_t row;
        off_t off;
    } rd_ptr_t;

    // Clear the word and byte offset bits so the address points at the start of its line
    function automatic addr_t alignLine(input addr_t addr);
        return {addr[XLEN-1:LINE_ADDR_LSB], {LINE_ADDR_LSB{1'b0}}};
    endfunction

    // Return the word offset of an address within its cache line
    function automatic off_t lineOffset(input addr_t addr);
        return addr[LINE_ADDR_LSB-1:BYTE_OFF_W];
    endfunction

    // Pick word k out of a line; word k sits at bits [XLEN*k +: XLEN]
    function automatic word_t selectWord(input line_t line, input off_t off);
        return line[off*XLEN +: XLEN];
    endfunction

    // The row pointers are equal except for the wrap bit, so every row holds unread data
    function automatic logic ptrFull(input ptr_t wrPtr, input ptr_t rdRow);
        return (wrPtr[ROW_W-1:0] == rdRow[ROW_W-1:0]) && (wrPtr[ROW_W] != rdRow[ROW_W]);
    endfunction

    // The row pointers are identical, including the wrap bit
    function automatic logic ptrEmpty(input ptr_t wrPtr, input ptr_t rdRow);
        return wrPtr == rdRow;
    endfunction

endpackage

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue between the instruction cache and dispatch.
// It fetches whole lines into a circular row buffer and hands out one instruction per read.
// A jump or branch flushes the buffer and restarts fetch at the line that holds the target.
`timescale 1ns/1ps
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic [XLEN-1:0]   pc_in,
    output logic              cache_rd_en,
    output logic              cache_abort,
    input  logic [LINE_W-1:0] dout,
    input  logic              dout_valid,
    output logic [XLEN-1:0]   pc_out,
    output logic [XLEN-1:0]   inst,
    output logic              empty,
    output logic              IFQ_FULL,
    input  logic              inst_rd_en,
    input  logic [XLEN-1:0]   jmp_branch_address,
    input  logic              jmp_branch_valid
);

    // Pointer and program-counter state
    ptr_t    wrPtr_q, wrPtr_d;
    rd_ptr_t rdPtr_q, rdPtr_d;
    addr_t   fetchPc_q, fetchPc_d;
    addr_t   headPc_q, headPc_d;

    // Line storage; it holds data only, so it needs no reset
    line_t rows_q [DEPTH];

    logic             isFull;
    logic             isEmpty;
    logic             doWrite;
    logic             doRead;
    logic [ROW_W-1:0] wrRow;
    logic [ROW_W-1:0] rdRow;
    off_t             lastOff;

    assign wrRow   = wrPtr_q[ROW_W-1:0];
    assign rdRow   = rdPtr_q.row[ROW_W-1:0];
    assign lastOff = off_t'(LINE_WORDS - 1);

    assign isFull  = ptrFull(wrPtr_q, rdPtr_q.row);
    assign isEmpty = ptrEmpty(wrPtr_q, rdPtr_q.row);

    // A redirect blocks the cache request in the same cycle and aborts any read in flight
    assign cache_rd_en = !isFull && !jmp_branch_valid;
    assign cache_abort = jmp_branch_valid;

    // A redirect overrides both the read and the write; doWrite is already gated by cache_rd_en
    assign doWrite = cache_rd_en && dout_valid;
    assign doRead  = inst_rd_en && !isEmpty && !jmp_branch_valid;

    assign pc_in    = fetchPc_q;
    assign pc_out   = headPc_q;
    assign inst     = selectWord(rows_q[rdRow], rdPtr_q.off);
    assign empty    = isEmpty;
    assign IFQ_FULL = isFull;

    // Compute the next pointers and PCs; a redirect takes priority over read and write
    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        fetchPc_d = fetchPc_q;
        headPc_d  = headPc_q;

        if (jmp_branch_valid) begin
            // Flush by moving the read row to the write row.
            // Fetch then restarts at the aligned line, and the head skips the words before the target.
            rdPtr_d.row = wrPtr_q;
            rdPtr_d.off = lineOffset(jmp_branch_address);
            fetchPc_d   = alignLine(jmp_branch_address);
            headPc_d    = jmp_branch_address;
        end else begin
            if (doWrite) begin
                wrPtr_d   = wrPtr_q + 1'b1;
                fetchPc_d = fetchPc_q + addr_t'(LINE_BYTES);
            end
            if (doRead) begin
                rdPtr_d.off = rdPtr_q.off + 1'b1;
                headPc_d    = headPc_q + addr_t'(WORD_BYTES);
                if (rdPtr_q.off == lastOff) begin
                    rdPtr_d.row = rdPtr_q.row + 1'b1;
                end
            end
        end
    end

    // Pointer and PC registers; reset empties the queue and restarts fetch at address zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            fetchPc_q <= '0;
            headPc_q  <= '0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            fetchPc_q <= fetchPc_d;
            headPc_q  <= headPc_d;
        end
    end

    // Capture an accepted cache line into the row at the write pointer
    always_ff @(posedge clk) begin
        if (doWrite) begin
            rows_q[wrRow] <= dout;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed testbench for instr_fetch_queue.
// A combinational cache model supplies mem[addr>>2] for each word of the requested line.
`timescale 1ns/1ps
module tb_instr_fetch_queue;

    localparam int XLEN   = 32;
    localparam int LW     = 4;
    localparam int LINE_W = XLEN * LW;

    logic              clk;
    logic              rst;
    logic [XLEN-1:0]   pc_in;
    logic              cache_rd_en;
    logic              cache_abort;
    logic [LINE_W-1:0] dout;
    logic              dout_valid;
    logic [XLEN-1:0]   pc_out;
    logic [XLEN-1:0]   inst;
    logic              empty;
    logic              IFQ_FULL;
    logic              inst_rd_en;
    logic [XLEN-1:0]   jmp_branch_address;
    logic              jmp_branch_valid;

    int compared   = 0;
    int mismatched = 0;

    instr_fetch_queue dut (
        .clk                (clk),
        .rst                (rst),
        .pc_in              (pc_in),
        .cache_rd_en        (cache_rd_en),
        .cache_abort        (cache_abort),
        .dout               (dout),
        .dout_valid         (dout_valid),
        .pc_out             (pc_out),
        .inst               (inst),
        .empty              (empty),
        .IFQ_FULL           (IFQ_FULL),
        .inst_rd_en         (inst_rd_en),
        .jmp_branch_address (jmp_branch_address),
        .jmp_branch_valid   (jmp_branch_valid)
    );

    // Free-running clock with a 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents: multiplying by an odd constant gives a distinct word for each index
    function automatic logic [31:0] memWord(input logic [29:0] idx);
        return (32'(idx) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Combinational cache: word k of the line is the instruction at pc_in + 4k
    always_comb begin
        dout = '0;
        for (int k = 0; k < LW; k++) begin
            dout[k*XLEN +: XLEN] = memWord(pc_in[31:2] + 30'(k));
        end
    end

    // Hold reset for two cycles, then release it at a falling edge with all inputs idle
    task automatic doReset();
        rst                = 1'b0;
        inst_rd_en         = 1'b0;
        jmp_branch_valid   = 1'b0;
        jmp_branch_address = '0;
        dout_valid         = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Check the output values while reset is held
    task automatic test_reset();
        @(negedge clk);
        compared++; if (empty !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_empty: got %0b expected 1", empty); end
        compared++; if (IFQ_FULL !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_full: got %0b expected 0", IFQ_FULL); end
        compared++; if (pc_in !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_pc_in: got %h expected 0", pc_in); end
        compared++; if (cache_rd_en !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_rd_en: got %0b expected 1", cache_rd_en); end
        compared++; if (cache_abort !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_abort: got %0b expected 0", cache_abort); end
    endtask

    // Fill all four rows without reading, then drain 16 words with the cache stalled
    task automatic test_fill_empty();
        doReset();
        repeat (3) @(negedge clk);
        compared++; if (IFQ_FULL !== 1'b0) begin mismatched++; $display("[TB] FAIL fill_not_full_3: got %0b expected 0", IFQ_FULL); end
        @(negedge clk);
        compared++; if (IFQ_FULL !== 1'b1) begin mismatched++; $display("[TB] FAIL fill_full: got %0b expected 1", IFQ_FULL); end
        compared++; if (pc_in !== 32'h40) begin mismatched++; $display("[TB] FAIL fill_pc_in: got %h expected 40", pc_in); end
        compared++; if (cache_rd_en !== 1'b0) begin mismatched++; $display("[TB] FAIL fill_rd_en: got %0b expected 0", cache_rd_en); end
        dout_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            compared++; if (empty !== 1'b0) begin mismatched++; $display("[TB] FAIL drain_empty[%0d]: got %0b expected 0", i, empty); end
            compared++; if (pc_out !== 32'(i*4)) begin mismatched++; $display("[TB] FAIL drain_pc[%0d]: got %h expected %h", i, pc_out, 32'(i*4)); end
            compared++; if (inst !== memWord(30'(i))) begin mismatched++; $display("[TB] FAIL drain_inst[%0d]: got %h expected %h", i, inst, memWord(30'(i))); end
            inst_rd_en = 1'b1;
            @(negedge clk);
        end
        inst_rd_en = 1'b0;
        compared++; if (empty !== 1'b1) begin mismatched++; $display("[TB] FAIL drain_end_empty: got %0b expected 1", empty); end
        dout_valid = 1'b1;
    endtask

    // Hold inst_rd_en from reset release; the PCs must be sequential across several row wraps
    task automatic test_continuous_read();
        doReset();
        inst_rd_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            compared++; if (empty !== 1'b0) begin mismatched++; $display("[TB] FAIL cont_empty[%0d]: got %0b expected 0", i, empty); end
            compared++; if (pc_out !== 32'(i*4)) begin mismatched++; $display("[TB] FAIL cont_pc[%0d]: got %h expected %h", i, pc_out, 32'(i*4)); end
            compared++; if (inst !== memWord(30'(i))) begin mismatched++; $display("[TB] FAIL cont_inst[%0d]: got %h expected %h", i, inst, memWord(30'(i))); end
            @(negedge clk);
        end
        inst_rd_en = 1'b0;
    endtask

    // Do five reads, then redirect to 0x104; the head must resume at 0x104 and count upward
    task automatic test_branch_after_reads();
        doReset();
        @(negedge clk);
        inst_rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            compared++; if (pc_out !== 32'(i*4)) begin mismatched++; $display("[TB] FAIL pre_branch_pc[%0d]: got %h expected %h", i, pc_out, 32'(i*4)); end
            @(negedge clk);
        end
        inst_rd_en         = 1'b0;
        jmp_branch_valid   = 1'b1;
        jmp_branch_address = 32'h104;
        #1;
        compared++; if (cache_abort !== 1'b1) begin mismatched++; $display("[TB] FAIL branch_abort: got %0b expected 1", cache_abort); end
        compared++; if (cache_rd_en !== 1'b0) begin mismatched++; $display("[TB] FAIL branch_rd_en: got %0b expected 0", cache_rd_en); end
        @(negedge clk);
        jmp_branch_valid = 1'b0;
        compared++; if (pc_in !== 32'h100) begin mismatched++; $display("[TB] FAIL branch_pc_in: got %h expected 100", pc_in); end
        compared++; if (empty !== 1'b1) begin mismatched++; $display("[TB] FAIL branch_flush_empty: got %0b expected 1", empty); end
        @(negedge clk);
        compared++; if (empty !== 1'b0) begin mismatched++; $display("[TB] FAIL branch_target_empty: got %0b expected 0", empty); end
        inst_rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            compared++; if (pc_out !== 32'(32'h104 + i*4)) begin mismatched++; $display("[TB] FAIL branch_pc[%0d]: got %h expected %h", i, pc_out, 32'(32'h104 + i*4)); end
            compared++; if (inst !== memWord(30'(32'h41 + i))) begin mismatched++; $display("[TB] FAIL branch_inst[%0d]: got %h expected %h", i, inst, memWord(30'(32'h41 + i))); end
            @(negedge clk);
        end
        inst_rd_en = 1'b0;
    endtask

    // Redirect while the queue is full and a read is requested; the read must be dropped
    task automatic test_branch_full_read();
        doReset();
        repeat (4) @(negedge clk);
        compared++; if (IFQ_FULL !== 1'b1) begin mismatched++; $display("[TB] FAIL bfull_full: got %0b expected 1", IFQ_FULL); end
        inst_rd_en         = 1'b1;
        jmp_branch_valid   = 1'b1;
        jmp_branch_address = 32'h200;
        @(negedge clk);
        inst_rd_en       = 1'b0;
        jmp_branch_valid = 1'b0;
        compared++; if (empty !== 1'b1) begin mismatched++; $display("[TB] FAIL bfull_flush_empty: got %0b expected 1", empty); end
        compared++; if (pc_in !== 32'h200) begin mismatched++; $display("[TB] FAIL bfull_pc_in: got %h expected 200", pc_in); end
        compared++; if (IFQ_FULL !== 1'b0) begin mismatched++; $display("[TB] FAIL bfull_not_full: got %0b expected 0", IFQ_FULL); end
        @(negedge clk);
        compared++; if (empty !== 1'b0) begin mismatched++; $display("[TB] FAIL bfull_target_empty: got %0b expected 0", empty); end
        compared++; if (pc_out !== 32'h200) begin mismatched++; $display("[TB] FAIL bfull_pc: got %h expected 200", pc_out); end
        compared++; if (inst !== memWord(30'h80)) begin mismatched++; $display("[TB] FAIL bfull_inst: got %h expected %h", inst, memWord(30'h80)); end
    endtask

    // Request reads while the queue is empty and the cache is stalled; nothing may move
    task automatic test_read_while_empty();
        doReset();
        dout_valid = 1'b0;
        inst_rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++; if (empty !== 1'b1) begin mismatched++; $display("[TB] FAIL rempty_empty[%0d]: got %0b expected 1", i, empty); end
        end
        compared++; if (pc_in !== 32'h0) begin mismatched++; $display("[TB] FAIL rempty_pc_in: got %h expected 0", pc_in); end
        dout_valid = 1'b1;
        inst_rd_en = 1'b0;
        @(negedge clk);
        compared++; if (empty !== 1'b0) begin mismatched++; $display("[TB] FAIL rempty_first_empty: got %0b expected 0", empty); end
        compared++; if (pc_out !== 32'h0) begin mismatched++; $display("[TB] FAIL rempty_first_pc: got %h expected 0", pc_out); end
        compared++; if (inst !== memWord(30'h0)) begin mismatched++; $display("[TB] FAIL rempty_first_inst: got %h expected %h", inst, memWord(30'h0)); end
    endtask

    // Assert reset between clock edges with two rows filled; the outputs must clear without a clock edge
    task automatic test_reset_mid();
        doReset();
        repeat (2) @(negedge clk);
        compared++; if (pc_in !== 32'h20) begin mismatched++; $display("[TB] FAIL rmid_pc_in_before: got %h expected 20", pc_in); end
        compared++; if (empty !== 1'b0) begin mismatched++; $display("[TB] FAIL rmid_empty_before: got %0b expected 0", empty); end
        #2;
        rst = 1'b0;
        #1;
        compared++; if (empty !== 1'b1) begin mismatched++; $display("[TB] FAIL rmid_empty: got %0b expected 1", empty); end
        compared++; if (IFQ_FULL !== 1'b0) begin mismatched++; $display("[TB] FAIL rmid_full: got %0b expected 0", IFQ_FULL); end
        compared++; if (pc_in !== 32'h0) begin mismatched++; $display("[TB] FAIL rmid_pc_in: got %h expected 0", pc_in); end
        @(negedge clk);
        rst        = 1'b1;
        inst_rd_en = 1'b1;
        @(negedge clk);
        compared++; if (pc_out !== 32'h0) begin mismatched++; $display("[TB] FAIL rmid_refetch_pc0: got %h expected 0", pc_out); end
        compared++; if (inst !== memWord(30'h0)) begin mismatched++; $display("[TB] FAIL rmid_refetch_inst0: got %h expected %h", inst, memWord(30'h0)); end
        @(negedge clk);
        compared++; if (pc_out !== 32'h4) begin mismatched++; $display("[TB] FAIL rmid_refetch_pc1: got %h expected 4", pc_out); end
        compared++; if (inst !== memWord(30'h1)) begin mismatched++; $display("[TB] FAIL rmid_refetch_inst1: got %h expected %h", inst, memWord(30'h1)); end
        inst_rd_en = 1'b0;
    endtask

    // Run every scenario in order, then print the summary
    initial begin
        rst                = 1'b0;
        inst_rd_en         = 1'b0;
        jmp_branch_valid   = 1'b0;
        jmp_branch_address = '0;
        dout_valid         = 1'b1;
        $display("[TB] starting instr_fetch_queue tests");
        test_reset();
        test_fill_empty();
        test_continuous_read();
        test_branch_after_reads();
        test_branch_full_read();
        test_read_while_empty();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
